// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Purpose  : Shared encodings for the MEM stage: data-memory access types
//            (DMType), write-back source select (WDSel), the bus FSM state
//            encoding and the default bus timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    // Access size / sign (DMType)
    localparam logic [2:0] DMT_WORD  = 3'd0;
    localparam logic [2:0] DMT_HALF  = 3'd1;
    localparam logic [2:0] DMT_HALFU = 3'd2;
    localparam logic [2:0] DMT_BYTE  = 3'd3;
    localparam logic [2:0] DMT_BYTEU = 3'd4;

    // Write-back source (WDSel)
    localparam logic [2:0] WDSEL_ALU = 3'd0;
    localparam logic [2:0] WDSEL_MEM = 3'd1;
    localparam logic [2:0] WDSEL_PC4 = 3'd2;
    localparam logic [2:0] WDSEL_IMM = 3'd3;

    // Maximum number of cycles spent in REQ or WAIT_R before aborting
    localparam int TIMEOUT_DEFAULT = 64;

    // Data-memory bus FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } state_e;

endpackage : mem_access_stage_pkg
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : req/gnt/rvalid data-memory bus between the MEM stage (master)
//            and a data memory or cache (slave).
// Signals  : req    - request valid (master)
//            we     - 1 = store (master)
//            addr   - word-aligned byte address (master)
//            be     - byte enables (master)
//            wdata  - lane-shifted store data (master)
//            gnt    - request accepted this cycle (slave)
//            rvalid - load data valid, at least one cycle after gnt (slave)
//            rdata  - raw 32-bit load word (slave)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface : mem_access_stage_if
`default_nettype wire

// File: rtl/mem_access_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_unit
// Purpose  : Purely combinational data alignment for a 32-bit little-endian
//            data port: byte-enable and store-lane generation, load lane
//            extraction with sign/zero extension, and alignment checking.
// Ports    : dmtype_i     - access size/sign (DMType encoding)
//            addr_lo_i    - byte offset within the word
//            store_data_i - unshifted store data (rs2)
//            load_word_i  - raw 32-bit word returned by memory
//            be_o         - byte enables for the access
//            store_word_o - store data replicated into every lane
//            load_data_o  - extracted and extended load result
//            misaligned_o - access crosses its natural alignment
// Revision : 1.0 - initial release
// ============================================================================
module mem_align_unit
    import mem_access_stage_pkg::*;
(
    input  wire logic [2:0]  dmtype_i,
    input  wire logic [1:0]  addr_lo_i,
    input  wire logic [31:0] store_data_i,
    input  wire logic [31:0] load_word_i,
    output logic      [3:0]  be_o,
    output logic      [31:0] store_word_o,
    output logic      [31:0] load_data_o,
    output logic             misaligned_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Lane selection is shared by both signed and unsigned variants
    always_comb begin
        half_sel = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_sel = load_word_i[7:0];
            2'd1:    byte_sel = load_word_i[15:8];
            2'd2:    byte_sel = load_word_i[23:16];
            default: byte_sel = load_word_i[31:24];
        endcase
    end

    always_comb begin
        be_o         = 4'b1111;
        store_word_o = store_data_i;
        load_data_o  = load_word_i;
        misaligned_o = 1'b0;
        case (dmtype_i)
            DMT_HALF, DMT_HALFU: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                // Replicating the halfword lets memory pick either lane via be
                store_word_o = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
                load_data_o  = (dmtype_i == DMT_HALF)
                             ? {{16{half_sel[15]}}, half_sel}
                             : {16'h0000, half_sel};
            end
            DMT_BYTE, DMT_BYTEU: begin
                be_o         = 4'b0001 << addr_lo_i;
                store_word_o = {4{store_data_i[7:0]}};
                load_data_o  = (dmtype_i == DMT_BYTE)
                             ? {{24{byte_sel[7]}}, byte_sel}
                             : {24'h000000, byte_sel};
            end
            default: begin
                // Word access (and any unused encoding) behaves as a word
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule : mem_align_unit
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of the 5-stage RV32I pipeline. Issues data-memory
//            accesses on a req/gnt/rvalid bus, aligns store/load data, stalls
//            the upstream pipeline while an access is outstanding, aborts
//            accesses that exceed TIMEOUT cycles, and registers the MEM/WB
//            result.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            *_in                - EX/MEM register fields
//            dmem                - data-memory bus (master side)
//            mem_stall           - hold IF..EX/MEM this cycle
//            misalign_exc        - one-cycle pulse after a misaligned access
//            bus_err             - one-cycle pulse after a timed-out access
//            wb_*                - MEM/WB register outputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,

    input  wire logic [31:0] pc_in,
    input  wire logic [31:0] inst_in,
    input  wire logic [31:0] alures_in,
    input  wire logic [31:0] rs2_data_in,
    input  wire logic [31:0] imm_in,
    input  wire logic [4:0]  rd_in,
    input  wire logic        MemWrite_in,
    input  wire logic        RegWrite_in,
    input  wire logic [2:0]  DMType_in,
    input  wire logic [2:0]  WDSel_in,

    mem_access_stage_if.master dmem,

    output logic             mem_stall,
    output logic             misalign_exc,
    output logic             bus_err,
    output logic             wb_regwrite,
    output logic      [4:0]  wb_rd,
    output logic      [31:0] wb_wdata,
    output logic      [31:0] wb_pc,
    output logic      [31:0] wb_inst
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Access decode and alignment
    // ------------------------------------------------------------------
    logic        is_load;
    logic        is_access;
    logic        misaligned;
    logic        aligned_access;
    logic        misalign_hit;
    logic [31:0] load_data;

    assign is_load        = (WDSel_in == WDSEL_MEM);
    assign is_access      = is_load | MemWrite_in;
    assign aligned_access = is_access & ~misaligned;
    assign misalign_hit   = is_access & misaligned;

    mem_align_unit u_align (
        .dmtype_i     (DMType_in),
        .addr_lo_i    (alures_in[1:0]),
        .store_data_i (rs2_data_in),
        .load_word_i  (dmem.rdata),
        .be_o         (dmem.be),
        .store_word_o (dmem.wdata),
        .load_data_o  (load_data),
        .misaligned_o (misaligned)
    );

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req;
    logic             store_done;
    logic             load_done;
    logic             timeout;
    logic             complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req        = 1'b0;
        store_done = 1'b0;
        load_done  = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_access) begin
                    req   = 1'b1;
                    cnt_d = '0;
                    if (dmem.gnt) begin
                        if (is_load) state_d = ST_WAIT_R;
                        else         store_done = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (dmem.gnt) begin
                    cnt_d = '0;
                    if (is_load) begin
                        state_d = ST_WAIT_R;
                    end else begin
                        store_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Request never accepted: withdraw it and retire as error
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (dmem.rvalid) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign complete  = store_done | load_done | timeout;
    assign mem_stall = aligned_access & ~complete;

    // Bus is forced quiet during reset even if a transaction was in flight
    assign dmem.req  = req & ~rst;
    assign dmem.we   = req & ~rst & MemWrite_in;
    assign dmem.addr = {alures_in[31:2], 2'b00};

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic [31:0] wb_wdata_d;

    always_comb begin
        case (WDSel_in)
            WDSEL_MEM: wb_wdata_d = load_data;
            WDSEL_PC4: wb_wdata_d = pc_in + 32'd4;
            WDSEL_IMM: wb_wdata_d = imm_in;
            default:   wb_wdata_d = alures_in;
        endcase
    end

    logic        misalign_exc_q;
    logic        bus_err_q;
    logic        wb_regwrite_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_wdata_q;
    logic [31:0] wb_pc_q;
    logic [31:0] wb_inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_exc_q <= 1'b0;
            bus_err_q      <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_wdata_q     <= 32'd0;
            wb_pc_q        <= 32'd0;
            wb_inst_q      <= 32'd0;
        end else begin
            misalign_exc_q <= misalign_hit;
            bus_err_q      <= timeout;
            if (!mem_stall) begin
                // Faulting accesses still retire, but must not write rd
                wb_regwrite_q <= RegWrite_in & ~misalign_hit & ~timeout;
                wb_rd_q       <= rd_in;
                wb_wdata_q    <= wb_wdata_d;
                wb_pc_q       <= pc_in;
                wb_inst_q     <= inst_in;
            end else begin
                // Bubble into write-back; data fields keep their last value
                wb_regwrite_q <= 1'b0;
                wb_rd_q       <= 5'd0;
            end
        end
    end

    assign misalign_exc = misalign_exc_q;
    assign bus_err      = bus_err_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_rd        = wb_rd_q;
    assign wb_wdata     = wb_wdata_q;
    assign wb_pc        = wb_pc_q;
    assign wb_inst      = wb_inst_q;

endmodule : mem_access_stage
`default_nettype wire
